// File: rtl/mips_cpu_lsu.sv
// Load/store unit between the multicycle MIPS core and an Avalon-MM master port.
// Takes one load or store at a time and runs the Avalon read/write handshake.
// It builds byte enables and lane-replicated store data, and returns load data
// with sign or zero extension. Misaligned requests, illegal sizes and stalled
// bus cycles (when a timeout is configured) finish with an error response.
module mips_cpu_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    input  logic                  waitrequest,
    output logic [31:0]           writedata,
    output logic [3:0]            byteenable,
    input  logic [31:0]           readdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // The stall counter still exists with the timeout disabled; the abort
    // compare is then gated off so the counter has no effect.
    localparam bit                TIMEOUT_EN  = (TIMEOUT_CYCLES > 0);
    localparam int                CNT_W       = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int                STALL_LAST  = TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0]  STALL_LIMIT = CNT_W'(STALL_LAST);

    logic [1:0]       state;
    logic             write_l;
    logic [1:0]       size_l;
    logic             signed_l;
    logic [1:0]       lane_l;
    logic [CNT_W-1:0] stall_cnt;
    logic             bad_access;
    logic [3:0]       be_next;
    logic [31:0]      wd_next;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_ext;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign read      = (state == ST_REQ) && !write_l;
    assign write     = (state == ST_REQ) && write_l;

    // Classify the incoming request and build its lane enables and store data
    always_comb begin
        bad_access = 1'b0;
        be_next    = 4'b1111;
        wd_next    = req_wdata;
        case (req_size)
            2'b00: begin
                be_next = 4'b0001 << req_addr[1:0];
                wd_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                bad_access = req_addr[0];
                be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_next    = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                bad_access = (req_addr[1:0] != 2'b00);
            end
            default: begin
                bad_access = 1'b1;
            end
        endcase
    end

    // Pick the addressed lanes out of the returned word and extend them
    always_comb begin
        case (lane_l)
            2'd0:    byte_sel = readdata[7:0];
            2'd1:    byte_sel = readdata[15:8];
            2'd2:    byte_sel = readdata[23:16];
            default: byte_sel = readdata[31:24];
        endcase
        half_sel = lane_l[1] ? readdata[31:16] : readdata[15:0];
        case (size_l)
            2'b00:   load_ext = signed_l ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
            2'b01:   load_ext = signed_l ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
            default: load_ext = readdata;
        endcase
    end

    // Transaction sequencing, request latching and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            write_l    <= 1'b0;
            size_l     <= 2'b00;
            signed_l   <= 1'b0;
            lane_l     <= 2'b00;
            stall_cnt  <= '0;
            address    <= '0;
            byteenable <= 4'b0000;
            writedata  <= 32'd0;
            rsp_rdata  <= 32'd0;
            rsp_error  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_l    <= req_write;
                        size_l     <= req_size;
                        signed_l   <= req_signed;
                        lane_l     <= req_addr[1:0];
                        address    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        byteenable <= be_next;
                        writedata  <= wd_next;
                        stall_cnt  <= '0;
                        if (bad_access) begin
                            rsp_error <= 1'b1;
                            rsp_rdata <= 32'd0;
                            state     <= ST_RESP;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (!waitrequest) begin
                        if (write_l) begin
                            rsp_error <= 1'b0;
                            rsp_rdata <= 32'd0;
                            state     <= ST_RESP;
                        end else begin
                            state <= ST_RDATA;
                        end
                    end else if (TIMEOUT_EN && (stall_cnt == STALL_LIMIT)) begin
                        rsp_error <= 1'b1;
                        rsp_rdata <= 32'd0;
                        state     <= ST_RESP;
                    end else begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
                ST_RDATA: begin
                    rsp_rdata <= load_ext;
                    rsp_error <= 1'b0;
                    state     <= ST_RESP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Self-checking bench for mips_cpu_lsu: directed scenarios plus randomized
// transactions checked against a behavioural model of the access rules.
module tb_mips_cpu_lsu;

    localparam int TMO = 4;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] address;
    logic        read, write, waitrequest;
    logic [31:0] writedata, readdata;
    logic [3:0]  byteenable;

    // Second instance with the timeout disabled
    logic        req_valid0, req_ready0, req_write0, req_signed0;
    logic [1:0]  req_size0;
    logic [31:0] req_addr0, req_wdata0;
    logic        rsp_valid0, rsp_error0;
    logic [31:0] rsp_rdata0, address0, writedata0, readdata0;
    logic        read0, write0, waitrequest0;
    logic [3:0]  byteenable0;

    int vectors;
    int miscompares;

    mips_cpu_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata)
    );

    mips_cpu_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_size(req_size0), .req_signed(req_signed0), .req_addr(req_addr0),
        .req_wdata(req_wdata0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
        .rsp_error(rsp_error0), .address(address0), .read(read0), .write(write0),
        .waitrequest(waitrequest0), .writedata(writedata0), .byteenable(byteenable0),
        .readdata(readdata0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << (a % 4));
        if (sz == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w % 256) * 32'h0101_0101;
        if (sz == 2'd1) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                               input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * (a % 4))) % 256;
            if (sg && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * ((a % 4) / 2))) % 65536;
            if (sg && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- transaction driver (collects observations only) ----------------
    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int stall,
                           output int lat, output int rd_cnt, output int wr_cnt,
                           output int valid_cnt, output logic both, output logic unstable,
                           output logic [31:0] b_addr, output logic [3:0] b_be,
                           output logic [31:0] b_wd, output logic [31:0] r_data,
                           output logic r_err);
        int   bus_cnt;
        int   wait_cnt;
        logic prev_acc;
        lat = 0; rd_cnt = 0; wr_cnt = 0; valid_cnt = 0; both = 0; unstable = 0;
        b_addr = '0; b_be = '0; b_wd = '0; r_data = 'x; r_err = 'x;
        bus_cnt = 0; prev_acc = 0; wait_cnt = 0;
        while (req_ready !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 40; k++) begin
            if (read === 1'b1 || write === 1'b1) begin
                bus_cnt++;
                if (read === 1'b1) rd_cnt++;
                if (write === 1'b1) wr_cnt++;
                if (read === 1'b1 && write === 1'b1) both = 1'b1;
                if (bus_cnt == 1) begin
                    b_addr = address; b_be = byteenable; b_wd = writedata;
                end else if (address !== b_addr || byteenable !== b_be || writedata !== b_wd) begin
                    unstable = 1'b1;
                end
            end
            if (rsp_valid === 1'b1) begin
                valid_cnt++;
                if (lat == 0) begin
                    lat = k; r_data = rsp_rdata; r_err = rsp_error;
                end
            end
            readdata = prev_acc ? rd : $urandom;
            if (read === 1'b1 || write === 1'b1) waitrequest = (bus_cnt <= stall);
            else waitrequest = 1'($urandom);
            prev_acc = (read === 1'b1) && (waitrequest === 1'b0);
            if (lat != 0 && k >= lat + 2) break;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
        req_signed = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
        waitrequest = 1'b0; readdata = 32'h0;
        #2 reset = 1'b0;
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
        vectors++; if ({read, write, rsp_valid, rsp_error} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b expected 0000", {read, write, rsp_valid, rsp_error}); end
        vectors++; if (rsp_rdata !== 32'd0 || address !== 32'd0 || writedata !== 32'd0 || byteenable !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_data: got rdata %h addr %h wd %h be %b expected all zero", rsp_rdata, address, writedata, byteenable); end
        @(negedge clk); @(negedge clk);
        vectors++; if (req_ready !== 1'b1 || read !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ignores_req: got ready %b read %b expected 1 0", req_ready, read); end
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_store();
        int lat, rc, wc, vc; logic both, unst, err; logic [31:0] ba, bw, rdat; logic [3:0] bb;
        run_txn(1'b1, 2'd2, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0,
                lat, rc, wc, vc, both, unst, ba, bb, bw, rdat, err);
        vectors++; if (wc !== 1 || rc !== 0) begin miscompares++; $display("[TB] FAIL sw_bus_cycles: got wr %0d rd %0d expected 1 0", wc, rc); end
        vectors++; if (ba !== 32'h0000_1004 || bb !== 4'b1111 || bw !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL sw_bus_fields: got %h %b %h expected 00001004 1111 deadbeef", ba, bb, bw); end
        vectors++; if (lat !== 2 || vc !== 1) begin miscompares++; $display("[TB] FAIL sw_latency: got lat %0d pulses %0d expected 2 1", lat, vc); end
        vectors++; if (err !== 1'b0 || rdat !== 32'd0) begin miscompares++; $display("[TB] FAIL sw_rsp: got err %b rdata %h expected 0 0", err, rdat); end
    endtask

    task automatic test_byte_loads();
        int lat, rc, wc, vc; logic both, unst, err; logic [31:0] ba, bw, rdat; logic [3:0] bb;
        for (int s = 1; s >= 0; s--) begin
            run_txn(1'b0, 2'd0, 1'(s), 32'h0000_2003, 32'h0, 32'h8012_3456, 0,
                    lat, rc, wc, vc, both, unst, ba, bb, bw, rdat, err);
            vectors++; if (bb !== 4'b1000 || ba !== 32'h0000_2000 || rc !== 1) begin miscompares++; $display("[TB] FAIL lb_bus signed=%0d: got be %b addr %h rd %0d expected 1000 00002000 1", s, bb, ba, rc); end
            vectors++; if (rdat !== (s ? 32'hFFFF_FF80 : 32'h0000_0080) || err !== 1'b0) begin miscompares++; $display("[TB] FAIL lb_data signed=%0d: got %h err %b expected %h 0", s, rdat, err, s ? 32'hFFFF_FF80 : 32'h0000_0080); end
            vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL lb_latency signed=%0d: got %0d expected 3", s, lat); end
        end
    endtask

    task automatic test_stalled_half();
        int lat, rc, wc, vc; logic both, unst, err; logic [31:0] ba, bw, rdat; logic [3:0] bb;
        run_txn(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_ABCD, 3,
                lat, rc, wc, vc, both, unst, ba, bb, bw, rdat, err);
        vectors++; if (rc !== 4 || unst !== 1'b0) begin miscompares++; $display("[TB] FAIL lh_stall_read: got cycles %0d unstable %b expected 4 0", rc, unst); end
        vectors++; if (ba !== 32'h0000_2000 || bb !== 4'b1100) begin miscompares++; $display("[TB] FAIL lh_bus: got %h %b expected 00002000 1100", ba, bb); end
        vectors++; if (rdat !== 32'hFFFF_8001 || lat !== 6) begin miscompares++; $display("[TB] FAIL lh_data: got %h lat %0d expected ffff8001 6", rdat, lat); end
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0,
                lat, rc, wc, vc, both, unst, ba, bb, bw, rdat, err);
        vectors++; if (bw !== 32'hBEEF_BEEF || bb !== 4'b1100) begin miscompares++; $display("[TB] FAIL sh_wdata: got %h %b expected beefbeef 1100", bw, bb); end
    endtask

    task automatic test_misaligned();
        int lat, rc, wc, vc; logic both, unst, err; logic [31:0] ba, bw, rdat; logic [3:0] bb;
        logic [31:0] addrs [2];
        logic [1:0]  sizes [2];
        addrs[0] = 32'h0000_1001; sizes[0] = 2'd1;
        addrs[1] = 32'h0000_1002; sizes[1] = 2'd2;
        for (int i = 0; i < 2; i++) begin
            run_txn(i == 0, sizes[i], 1'b0, addrs[i], 32'h1234_5678, 32'hFFFF_FFFF, 0,
                    lat, rc, wc, vc, both, unst, ba, bb, bw, rdat, err);
            vectors++; if (rc !== 0 || wc !== 0) begin miscompares++; $display("[TB] FAIL misalign_bus %0d: got rd %0d wr %0d expected 0 0", i, rc, wc); end
            vectors++; if (lat !== 1 || err !== 1'b1 || rdat !== 32'd0) begin miscompares++; $display("[TB] FAIL misalign_rsp %0d: got lat %0d err %b rdata %h expected 1 1 0", i, lat, err, rdat); end
        end
    endtask

    task automatic test_timeout();
        int lat, rc, wc, vc; logic both, unst, err; logic [31:0] ba, bw, rdat; logic [3:0] bb;
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0, 32'h5555_AAAA, 1000,
                lat, rc, wc, vc, both, unst, ba, bb, bw, rdat, err);
        vectors++; if (rc !== TMO || wc !== 0) begin miscompares++; $display("[TB] FAIL timeout_read_cycles: got %0d expected %0d", rc, TMO); end
        vectors++; if (lat !== TMO + 1 || err !== 1'b1 || rdat !== 32'd0) begin miscompares++; $display("[TB] FAIL timeout_rsp: got lat %0d err %b rdata %h expected %0d 1 0", lat, err, rdat, TMO + 1); end
    endtask

    task automatic test_no_timeout();
        int high_cnt;
        int pulse_cnt;
        high_cnt = 0; pulse_cnt = 0;
        req_valid0 = 1'b1; req_write0 = 1'b0; req_size0 = 2'd2; req_signed0 = 1'b0;
        req_addr0 = 32'h0000_0100; req_wdata0 = 32'h0; waitrequest0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (read0 === 1'b1) high_cnt++;
            if (rsp_valid0 === 1'b1) pulse_cnt++;
            @(negedge clk);
        end
        vectors++; if (high_cnt !== 100 || pulse_cnt !== 0) begin miscompares++; $display("[TB] FAIL no_timeout_hold: got read cycles %0d pulses %0d expected 100 0", high_cnt, pulse_cnt); end
    endtask

    task automatic test_reset_mid();
        int lat, rc, wc, vc, pulses; logic both, unst, err; logic [31:0] ba, bw, rdat; logic [3:0] bb;
        pulses = 0;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h0000_0200; waitrequest = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (read !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_pre: got read %b expected 1", read); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (read !== 1'b0 || req_ready !== 1'b1 || read0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_drop: got read %b ready %b read0 %b expected 0 1 0", read, req_ready, read0); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        reset = 1'b1; waitrequest = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("[TB] FAIL rst_mid_no_rsp: got %0d pulses expected 0", pulses); end
        run_txn(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 0,
                lat, rc, wc, vc, both, unst, ba, bb, bw, rdat, err);
        vectors++; if (lat !== 2 || wc !== 1 || ba !== 32'h0000_0010 || bw !== 32'hCAFE_F00D || err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_after_sw: got lat %0d wr %0d addr %h wd %h err %b expected 2 1 00000010 cafef00d 0", lat, wc, ba, bw, err); end
    endtask

    task automatic test_random();
        int lat, rc, wc, vc; logic both, unst, err; logic [31:0] ba, bw, rdat; logic [3:0] bb;
        logic wr, sg, e_err, tmo; logic [1:0] sz; logic [31:0] a, w, r, e_data;
        int stall, e_lat, e_bus;
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom_range(0, 3));
            a = $urandom; w = $urandom; r = $urandom; stall = $urandom_range(0, 6);
            run_txn(wr, sz, sg, a, w, r, stall, lat, rc, wc, vc, both, unst, ba, bb, bw, rdat, err);
            e_err  = model_err(sz, a);
            tmo    = !e_err && (stall >= TMO);
            e_bus  = e_err ? 0 : (tmo ? TMO : stall + 1);
            e_lat  = e_err ? 1 : (tmo ? TMO + 1 : (wr ? stall + 2 : stall + 3));
            e_data = (e_err || tmo || wr) ? 32'd0 : model_load(sz, sg, a, r);
            vectors++; if ((wr ? wc : rc) !== e_bus || (wr ? rc : wc) !== 0 || both || unst) begin miscompares++; $display("[TB] FAIL rnd%0d_bus: got rd %0d wr %0d both %b unstable %b expected %0d cycles of %s", n, rc, wc, both, unst, e_bus, wr ? "write" : "read"); end
            vectors++; if (lat !== e_lat || vc !== 1) begin miscompares++; $display("[TB] FAIL rnd%0d_latency: got %0d pulses %0d expected %0d 1", n, lat, vc, e_lat); end
            vectors++; if (err !== (e_err || tmo) || rdat !== e_data) begin miscompares++; $display("[TB] FAIL rnd%0d_rsp: got err %b rdata %h expected %b %h", n, err, rdat, e_err || tmo, e_data); end
            vectors++; if (address !== (a & 32'hFFFF_FFFC) || byteenable !== model_be(sz, a) || writedata !== model_wd(sz, w)) begin miscompares++; $display("[TB] FAIL rnd%0d_fields: got %h %b %h expected %h %b %h", n, address, byteenable, writedata, a & 32'hFFFF_FFFC, model_be(sz, a), model_wd(sz, w)); end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_size0 = 2'd0; req_signed0 = 1'b0;
        req_addr0 = 32'h0; req_wdata0 = 32'h0; waitrequest0 = 1'b0; readdata0 = 32'h0;
        test_reset();
        test_word_store();
        test_byte_loads();
        test_stalled_half();
        test_misaligned();
        test_timeout();
        test_no_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
